// File: rtl/sr_cntr_alu_pkg.sv
// ----------------------------------------------------------------------------
// sr_cntr_alu_pkg : state encoding and default sizes for the datapath sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sr_cntr_alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    INC     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sr_cntr_alu_piso.sv
// ----------------------------------------------------------------------------
// sr_cntr_alu_piso : parallel-in/serial-out register, MSB first, with bit count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sr_cntr_alu_piso
  import sr_cntr_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o,
  output logic             last_o
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      sr_d      = data_i;
      bit_cnt_d = BC_W'(WIDTH - 1);
    end else if (shift_i) begin
      // Zero fill means the register is empty once the last bit has gone out.
      sr_d = sr_q << 1;
      if (bit_cnt_q != '0) begin
        bit_cnt_d = bit_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign msb_o  = sr_q[WIDTH-1];
  assign last_o = (bit_cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/sr_cntr_alu_ctrl.sv
// ----------------------------------------------------------------------------
// sr_cntr_alu_ctrl : shift-in / N incs / settle / capture sequencer for SCHEME
// Rev 1.0 ; SR_CNTR_ALU_CTRL_ERR_EN adds sticky busy-start err output
// ----------------------------------------------------------------------------
`default_nettype none

module sr_cntr_alu_ctrl
  import sr_cntr_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] inc_count,
  output logic             ready,
  output logic             sch_d,
  output logic             sch_en,
  output logic             sch_inc,
  input  logic [WIDTH-1:0] sch_out,
  output logic [WIDTH-1:0] result,
  output logic             done
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
  ,
  output logic             err
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] inc_cnt_q, inc_cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, sch_en_q, sch_inc_q, done_q;
  logic             accept, piso_msb, piso_last;

  assign accept = start && ready_q;

  sr_cntr_alu_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .res     (res),
    .load_i  (accept),
    .shift_i (state_q == SHIFT),
    .data_i  (load_data),
    .msb_o   (piso_msb),
    .last_o  (piso_last)
  );

  always_comb begin
    state_d   = state_q;
    inc_cnt_d = inc_cnt_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          inc_cnt_d = inc_count;
        end
      end
      SHIFT: begin
        if (piso_last) begin
          state_d = (inc_cnt_q != '0) ? INC : SETTLE;
        end
      end
      INC: begin
        inc_cnt_d = inc_cnt_q - 1'b1;
        if (inc_cnt_q == CNT_W'(1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Datapath has had a full cycle to absorb the last inc; sample it now.
        state_d  = CAPTURE;
        result_d = sch_out;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= IDLE;
      inc_cnt_q <= '0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      sch_en_q  <= 1'b0;
      sch_inc_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      inc_cnt_q <= inc_cnt_d;
      result_q  <= result_d;
      ready_q   <= (state_d == IDLE);
      sch_en_q  <= (state_d == SHIFT);
      sch_inc_q <= (state_d == INC);
      done_q    <= (state_d == CAPTURE);
    end
  end

  assign ready   = ready_q;
  assign sch_en  = sch_en_q;
  assign sch_inc = sch_inc_q;
  assign sch_d   = piso_msb & sch_en_q;
  assign result  = result_q;
  assign done    = done_q;

`ifdef SR_CNTR_ALU_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!res) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (start && !ready_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_cntr_alu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sr_cntr_alu_ctrl : scoreboard bench driving a behavioural SCHEME datapath
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sr_cntr_alu_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic [CW-1:0] inc_count = '0;
  logic          ready, sch_d, sch_en, sch_inc, done;
  logic [W-1:0]  sch_out, result;
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
  logic          err;
`endif

  sr_cntr_alu_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .load_data (load_data),
    .inc_count (inc_count),
    .ready     (ready),
    .sch_d     (sch_d),
    .sch_en    (sch_en),
    .sch_inc   (sch_inc),
    .sch_out   (sch_out),
    .result    (result),
    .done      (done)
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: serial shift register plus an inc counter.
  logic [W-1:0] dp_sr = '0, dp_cnt = '0, noise = '0;
  always @(posedge clk) begin
    if (sch_en === 1'b1) dp_sr <= {dp_sr[W-2:0], sch_d};
    if (sch_inc === 1'b1) dp_cnt <= dp_cnt + 1'b1;
  end
  assign sch_out = dp_sr + dp_cnt + noise;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] acc = '0;
  logic [W-1:0] last_res = '0;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  logic done_prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
      end else begin
        e = sb.pop_front();
        last_res = e.res;
        if (result !== e.res || cyc != e.cyc) begin
          fails++;
          $display("FAIL done_result: result=%h at cycle %0d, required %h at cycle %0d",
                   result, cyc, e.res, e.cyc);
        end
      end
      tests++;
      if (done_prev === 1'b1) begin
        fails++;
        $display("FAIL done_width: done high on consecutive cycles at %0d, required one-cycle pulse", cyc);
      end
    end
    done_prev = done;
  end

  int           en_cnt, inc_cnt, first_en, last_en, first_inc, last_inc, done_off;
  logic [W-1:0] sd_bits;
  bit           err_ok;

  task automatic accept(input logic [W-1:0] ld, input logic [CW-1:0] n, output int a);
    @(negedge clk);
    start = 1'b1; load_data = ld; inc_count = n; a = cyc;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: ready=%b at accept, required 1", ready);
    end
    acc = acc + W'(n);
    sb.push_back('{W'(ld + acc), a + W + int'(n) + 2});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic observe(input int a, input int ncyc, input int pulse_off);
    en_cnt = 0; inc_cnt = 0; first_en = -1; last_en = -1;
    first_inc = -1; last_inc = -1; done_off = -1; sd_bits = '0; err_ok = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == pulse_off) begin
        start = 1'b1; load_data = 8'hFF; inc_count = 4'hF;
      end else if (pulse_off != 0) begin
        start = 1'b0;
      end
      if (sch_en === 1'b1) begin
        en_cnt++; sd_bits = {sd_bits[W-2:0], sch_d};
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (sch_inc === 1'b1) begin
        inc_cnt++;
        if (first_inc < 0) first_inc = k;
        last_inc = k;
      end
      if (done === 1'b1) done_off = cyc - a;
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
      if (pulse_off != 0 && k > pulse_off && err !== 1'b1) err_ok = 1'b0;
`endif
    end
  endtask

  task automatic test_reset();
    res = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ready, sch_en, sch_inc, sch_d, done} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: {ready,en,inc,d,done}=%b, required 10000",
               {ready, sch_en, sch_inc, sch_d, done});
    end
    tests++;
    if (result !== '0) begin
      fails++;
      $display("FAIL reset_result: result=%h, required 00", result);
    end
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: err=%b, required 0", err);
    end
`endif
    res = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_a5();
    int a;
    accept(8'hA5, 4'd0, a);
    observe(a, 12, 0);
    tests++;
    if (sd_bits !== 8'hA5 || en_cnt != 8 || first_en != 1 || last_en != 8) begin
      fails++;
      $display("FAIL a5_shift: bits=%h en=%0d span %0d..%0d, required A5 en=8 span 1..8",
               sd_bits, en_cnt, first_en, last_en);
    end
    tests++;
    if (inc_cnt != 0 || done_off != 10) begin
      fails++;
      $display("FAIL a5_timing: incs=%0d done_at=%0d, required incs=0 done_at=10", inc_cnt, done_off);
    end
  endtask

  task automatic test_inc3();
    int a;
    accept(8'h3C, 4'd3, a);
    observe(a, 15, 0);
    tests++;
    if (sd_bits !== 8'h3C || en_cnt != 8 || last_en != 8) begin
      fails++;
      $display("FAIL inc3_shift: bits=%h en=%0d last=%0d, required 3C en=8 last=8", sd_bits, en_cnt, last_en);
    end
    tests++;
    if (inc_cnt != 3 || first_inc != 9 || last_inc != 11 || done_off != 13) begin
      fails++;
      $display("FAIL inc3_timing: incs=%0d span %0d..%0d done_at=%0d, required 3 span 9..11 done_at=13",
               inc_cnt, first_inc, last_inc, done_off);
    end
  endtask

  task automatic test_reset_mid_shift();
    int a;
    accept(8'hA5, 4'd0, a);
    observe(a, 3, 0);
    @(negedge clk);
    res = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    tests++;
    if ({ready, sch_en, sch_inc, sch_d, done} !== 5'b10000) begin
      fails++;
      $display("FAIL midreset_ctrl: {ready,en,inc,d,done}=%b, required 10000",
               {ready, sch_en, sch_inc, sch_d, done});
    end
    tests++;
    if (result !== '0) begin
      fails++;
      $display("FAIL midreset_result: result=%h, required 00", result);
    end
    res = 1'b1;
    last_res = '0;
    observe(a, 16, 0);
    tests++;
    if (en_cnt != 0 || inc_cnt != 0 || done_off != -1) begin
      fails++;
      $display("FAIL midreset_idle: en=%0d inc=%0d done_at=%0d, required 0 0 none", en_cnt, inc_cnt, done_off);
    end
  endtask

  task automatic test_busy_start();
    int a;
    accept(8'h5A, 4'd2, a);
    observe(a, 16, 4);
    tests++;
    if (sd_bits !== 8'h5A || en_cnt != 8 || inc_cnt != 2 || done_off != 12) begin
      fails++;
      $display("FAIL busy_ignored: bits=%h en=%0d incs=%0d done_at=%0d, required 5A 8 2 12",
               sd_bits, en_cnt, inc_cnt, done_off);
    end
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
    tests++;
    if (!err_ok) begin
      fails++;
      $display("FAIL busy_err: err=%b dropped after busy start, required sticky 1", err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int a;
    int dones;
    @(negedge clk);
    start = 1'b1; load_data = 8'hC3; inc_count = 4'hF; a = cyc;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready0: ready=%b, required 1", ready);
    end
    acc = acc + 8'd15;
    sb.push_back('{W'(8'hC3 + acc), a + 25});
    acc = acc + 8'd15;
    sb.push_back('{W'(8'hC3 + acc), a + 51});
    en_cnt = 0; inc_cnt = 0; dones = 0;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      if (k == 27) start = 1'b0;
      if (sch_en === 1'b1) en_cnt++;
      if (sch_inc === 1'b1) inc_cnt++;
      if (done === 1'b1) dones++;
`ifdef SR_CNTR_ALU_CTRL_ERR_EN
      if (k == 1) begin
        tests++;
        if (err !== 1'b0) begin
          fails++;
          $display("FAIL b2b_err_clear: err=%b after accept, required 0", err);
        end
      end
`endif
      if (k == 25 || k == 26) begin
        tests++;
        if (ready !== (k == 26)) begin
          fails++;
          $display("FAIL b2b_ready: ready=%b at cycle %0d, required %0d", ready, k, k == 26);
        end
      end
      if (k == 27) begin
        tests++;
        if (sch_en !== 1'b1) begin
          fails++;
          $display("FAIL b2b_reaccept: sch_en=%b at cycle 27, required 1", sch_en);
        end
      end
    end
    tests++;
    if (en_cnt != 16 || inc_cnt != 30 || dones != 2) begin
      fails++;
      $display("FAIL b2b_counts: en=%0d incs=%0d dones=%0d, required 16 30 2", en_cnt, inc_cnt, dones);
    end
  endtask

  task automatic test_result_hold();
    for (int i = 0; i < 4; i++) begin
      noise = W'($urandom);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      tests++;
      if (result !== last_res) begin
        fails++;
        $display("FAIL result_hold: result=%h with sch_out=%h, required %h", result, sch_out, last_res);
      end
    end
    noise = '0;
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_inc3();
    test_reset_mid_shift();
    test_busy_start();
    test_back_to_back();
    test_result_hold();
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_done: %0d operations never signalled done, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/sr_cntr_alu_ctrl.md
# sr_cntr_alu_ctrl

Sequencer for the shift-register/counter/ALU datapath (SCHEME). It accepts a parallel operand and an increment count over a start/ready handshake, then drives the datapath in order: serial shift-in on `d` with `EN`, N `inc` pulses, one settle cycle. It then captures the datapath's 8-bit `out` into a result register and pulses `done`. It replaces free-running bench stimulus with deterministic, cycle-exact control.

## Interface
- `WIDTH`, 8: operand/result width; must equal the datapath's `out` width.
- `CNT_W`, 4: width of the increment-count field (max N = 2^CNT_W−1).
- `clk` in 1: single clock; all logic on rising edge.
- `res` in 1: reset, synchronous, active-low.
- `start` in 1: request; accepted on a rising edge where `start=1` and `ready=1`.
- `load_data` in WIDTH: operand, sampled at acceptance, shifted out MSB first.
- `inc_count` in CNT_W: number of `inc` pulses, sampled at acceptance.
- `ready` out 1: idle, can accept `start`.
- `sch_d` out 1: serial data to datapath `d`.
- `sch_en` out 1: to datapath `EN`.
- `sch_inc` out 1: to datapath `inc`.
- `sch_out` in WIDTH: datapath `out`.
- `result` out WIDTH: captured `sch_out`, held until the next capture.
- `done` out 1: one-cycle pulse, `result` valid.

## Operation
- States: IDLE, SHIFT, INC, SETTLE, CAPTURE.
- IDLE:
  - `ready=1`; all `sch_*` outputs are 0.
  - On accept: `load_data` goes to the shift register, `inc_count` to the inc counter, bit counter ← WIDTH−1; next state SHIFT.
- SHIFT:
  - `sch_en=1`; `sch_d` = shift register MSB.
  - Shift register shifts left each cycle; stays exactly WIDTH cycles.
  - Then goes to INC if inc count ≠ 0, else to SETTLE.
- INC:
  - `sch_inc=1`; `sch_en=0`; `sch_d=0`.
  - Inc counter decrements each cycle; exits to SETTLE after the cycle where the count was 1.
- SETTLE: all `sch_*` outputs 0 for one cycle.
- CAPTURE:
  - `result` ← `sch_out` on entry edge; `done=1` for this one cycle.
  - Next state IDLE. `ready=0` during CAPTURE.
- `start` while `ready=0` is ignored; operands latched at acceptance are unaffected.
- `inc_count=0`: INC is skipped entirely.
- Reset (`res=0` at an edge, in any state, including mid-SHIFT or mid-INC):
  - Next state IDLE.
  - `ready=1`, `sch_d=0`, `sch_en=0`, `sch_inc=0`, `done=0`, `result=0`.
  - Shift register and both counters cleared.
  - An in-flight operation is discarded, with no `done`.
- Outputs are registered; no combinational path from inputs to outputs.

## Timing
- Accept edge at cycle 0. SHIFT occupies cycles 1..WIDTH; INC occupies WIDTH+1..WIDTH+N.
- SETTLE is at WIDTH+N+1. CAPTURE/`done` is at WIDTH+N+2; `ready` returns at WIDTH+N+3.
- Latency from accept to `done` is WIDTH+N+2 cycles; the default with N=0 is 10.
- Back-to-back: `start` held high is accepted again on the edge ending the first `ready=1` cycle. Minimum spacing is WIDTH+N+3 cycles.
- `sch_d` bit i (MSB = i 0) is valid during SHIFT cycle i+1, coincident with `sch_en=1`.

## Configuration
- `SR_CNTR_ALU_CTRL_ERR_EN` defined:
  - Adds output `err` (1 bit), sticky.
  - Set on any edge with `start=1` and `ready=0`.
  - Cleared by reset or by the next accepted `start`.
- Undefined: no `err` port; busy starts are silently ignored.

## Structure
- Package `sr_cntr_alu_pkg`:
  - State encoding constants (IDLE=0, SHIFT=1, INC=2, SETTLE=3, CAPTURE=4, 3-bit).
  - Default WIDTH and CNT_W.
- One sub-module, `sr_cntr_alu_piso`: parallel-in/serial-out shift register with `load`, `shift`, and `msb` output, plus its own bit counter and `last` flag.
- The FSM, inc counter and result register stay in the top.

## Test plan
- Reset mid-SHIFT (after 3 bits) → next cycle `ready=1`, all `sch_*=0`, no `done`, `result=0`.
- Accept with `load_data=8'hA5`, `inc_count=0` → `sch_d` sequence 1,0,1,0,0,1,0,1 over 8 `sch_en` cycles; no `sch_inc`; `done` 10 cycles after accept; `result` equals the `sch_out` value at CAPTURE.
- `load_data=8'h3C`, `inc_count=3` → 8 `sch_en` cycles, then exactly 3 consecutive `sch_inc` cycles, 1 settle, `done` at cycle 13.
- `start` pulsed at cycle 4 of a busy operation → ignored, first operation completes unchanged. With `SR_CNTR_ALU_CTRL_ERR_EN`: `err=1` from cycle 5 until the next accepted start.
- `start` held high continuously with `inc_count=15` → accepts every 26 cycles; each `done` is exactly one cycle wide.
- Sample `result` at arbitrary times between operations → holds the last captured value until the next CAPTURE.
